// File: rtl/vlog_rr_arb_fsm.sv
// N-channel request/grant arbiter: round-robin or fixed priority, with an optional hold limit.
// Latency: one edge from sampled request to visible grant; at least one idle cycle between grants.
// Backpressure: a grant is held while its request stays high, unless the hold limit preempts it.
module vlog_rr_arb_fsm #(
    parameter  int N_REQ    = 4,
    parameter  int MODE     = 0,
    parameter  int MAX_HOLD = 8,
    localparam int IDW      = $clog2(N_REQ)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] gnt,
    output logic [IDW-1:0]   gnt_id,
    output logic             busy,
    output logic             preempt
);

    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_GRANT = 2'b01;
    localparam bit         HOLD_EN  = (MAX_HOLD != 0);
    localparam logic [7:0] HOLD_LIM = 8'(MAX_HOLD);
    localparam logic [7:0] HOLD_SAT = 8'hFF;

    logic [1:0]       state_q,   state_d;
    logic [N_REQ-1:0] gnt_q,     gnt_d;
    logic [IDW-1:0]   gnt_id_q,  gnt_id_d;
    logic [IDW-1:0]   last_q,    last_d;
    logic [7:0]       hold_q,    hold_d;
    logic             preempt_q, preempt_d;

    logic [IDW-1:0]   winner;
    logic             holder_req;
    logic             others_req;
    logic             limit_hit;

    // First set request scanning last+1, last+2, ... with wrap-around.
    function automatic logic [IDW-1:0] pick_rr(input logic [N_REQ-1:0] r,
                                               input logic [IDW-1:0]   last);
        logic [IDW-1:0] w;
        int             idx;
        w = '0;
        for (int i = N_REQ; i >= 1; i--) begin
            idx = (int'(last) + i) % N_REQ;
            if (r[idx]) begin
                w = IDW'(idx);
            end
        end
        return w;
    endfunction

    function automatic logic [IDW-1:0] pick_fixed(input logic [N_REQ-1:0] r);
        logic [IDW-1:0] w;
        w = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (r[i]) begin
                w = IDW'(i);
            end
        end
        return w;
    endfunction

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            gnt_q     <= '0;
            gnt_id_q  <= '0;
            last_q    <= IDW'(N_REQ - 1);
            hold_q    <= '0;
            preempt_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            gnt_id_q  <= gnt_id_d;
            last_q    <= last_d;
            hold_q    <= hold_d;
            preempt_q <= preempt_d;
        end
    end

    always_comb begin
        winner     = (MODE == 1) ? pick_fixed(req) : pick_rr(req, last_q);
        holder_req = |(req & gnt_q);
        others_req = |(req & ~gnt_q);
        // Compared with >= so a late second requester still preempts a saturated holder.
        limit_hit  = HOLD_EN && (hold_q >= HOLD_LIM);

        state_d    = state_q;
        gnt_d      = gnt_q;
        gnt_id_d   = gnt_id_q;
        last_d     = last_q;
        hold_d     = hold_q;
        preempt_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                gnt_d    = '0;
                gnt_id_d = '0;
                if (|req) begin
                    state_d  = ST_GRANT;
                    gnt_d    = {{(N_REQ-1){1'b0}}, 1'b1} << winner;
                    gnt_id_d = winner;
                    last_d   = winner;
                    hold_d   = 8'd1;
                end
            end
            ST_GRANT: begin
                if (!holder_req) begin
                    state_d  = ST_IDLE;
                    gnt_d    = '0;
                    gnt_id_d = '0;
                    hold_d   = '0;
                end else if (limit_hit && others_req) begin
                    state_d   = ST_IDLE;
                    gnt_d     = '0;
                    gnt_id_d  = '0;
                    hold_d    = '0;
                    preempt_d = 1'b1;
                end else if (hold_q != HOLD_SAT) begin
                    hold_d = hold_q + 8'd1;
                end
            end
            default: begin
                state_d  = ST_IDLE;
                gnt_d    = '0;
                gnt_id_d = '0;
                hold_d   = '0;
            end
        endcase
    end

    always_comb begin
        gnt     = gnt_q;
        gnt_id  = gnt_id_q;
        busy    = |gnt_q;
        preempt = preempt_q;
    end

endmodule

// File: tb/tb_vlog_rr_arb_fsm.sv
// Bench for vlog_rr_arb_fsm: three instances (RR/limit 8, fixed/limit 8, RR/unlimited) against
// a grant-history model, directed scenarios with literal expectations, then random traffic.
module tb_vlog_rr_arb_fsm;

    localparam int N = 4;
    localparam int NI = 3;
    localparam int MODE_A [NI] = '{0, 1, 0};
    localparam int MAXH_A [NI] = '{8, 8, 0};

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [NI-1:0][N-1:0] req_i = '0;
    logic [NI-1:0][N-1:0] gnt_o;
    logic [NI-1:0][1:0]   gnt_id_o;
    logic [NI-1:0]        busy_o;
    logic [NI-1:0]        pre_o;

    int n_chk = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    vlog_rr_arb_fsm #(.N_REQ(N), .MODE(0), .MAX_HOLD(8)) u0 (
        .clock(clk), .reset(reset), .req(req_i[0]), .gnt(gnt_o[0]),
        .gnt_id(gnt_id_o[0]), .busy(busy_o[0]), .preempt(pre_o[0]));
    vlog_rr_arb_fsm #(.N_REQ(N), .MODE(1), .MAX_HOLD(8)) u1 (
        .clock(clk), .reset(reset), .req(req_i[1]), .gnt(gnt_o[1]),
        .gnt_id(gnt_id_o[1]), .busy(busy_o[1]), .preempt(pre_o[1]));
    vlog_rr_arb_fsm #(.N_REQ(N), .MODE(0), .MAX_HOLD(0)) u2 (
        .clock(clk), .reset(reset), .req(req_i[2]), .gnt(gnt_o[2]),
        .gnt_id(gnt_id_o[2]), .busy(busy_o[2]), .preempt(pre_o[2]));

    // Model: who holds the resource (-1 = nobody), for how long, who won last, preempt pulse.
    int m_cur  [NI];
    int m_hold [NI];
    int m_last [NI];
    int m_pre  [NI];

    function automatic int pick(int mode, int last, logic [N-1:0] r);
        if (mode == 1) begin
            for (int c = 0; c < N; c++) if (r[c]) return c;
        end else begin
            for (int k = 1; k <= N; k++) if (r[(last + k) % N]) return (last + k) % N;
        end
        return -1;
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < NI; i++) begin
            logic [N-1:0] r;
            r = req_i[i];
            m_pre[i] = 0;
            if (reset) begin
                m_cur[i] = -1; m_hold[i] = 0; m_last[i] = N - 1;
            end else if (m_cur[i] < 0) begin
                if (r != 0) begin
                    m_cur[i]  = pick(MODE_A[i], m_last[i], r);
                    m_last[i] = m_cur[i];
                    m_hold[i] = 1;
                end
            end else if (!r[m_cur[i]]) begin
                m_cur[i] = -1;
            end else if (MAXH_A[i] != 0 && m_hold[i] >= MAXH_A[i] && (r & ~(4'b1 << m_cur[i])) != 0) begin
                m_cur[i] = -1;
                m_pre[i] = 1;
            end else begin
                m_hold[i] = (m_hold[i] >= 255) ? 255 : m_hold[i] + 1;
            end
        end
    end

    task automatic chk(string name, int act, int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < NI; i++) begin
                chk($sformatf("u%0d.gnt", i),    int'(gnt_o[i]),    m_cur[i] < 0 ? 0 : (1 << m_cur[i]));
                chk($sformatf("u%0d.gnt_id", i), int'(gnt_id_o[i]), m_cur[i] < 0 ? 0 : m_cur[i]);
                chk($sformatf("u%0d.busy", i),   int'(busy_o[i]),   m_cur[i] < 0 ? 0 : 1);
                chk($sformatf("u%0d.preempt", i), int'(pre_o[i]),   m_pre[i]);
                chk($sformatf("u%0d.onehot", i), int'($onehot0(gnt_o[i])), 1);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_pulse();
        reset = 1'b1;
        req_i = '0;
        step();
        reset = 1'b0;
    endtask

    initial begin : stim
        int dropped [NI];
        int ord [$];
        int u1_ch3;
        int pre_seen;
        logic prev_busy;
        int exp_g [10];
        int exp_p [10];

        for (int i = 0; i < NI; i++) begin
            m_cur[i] = -1; m_hold[i] = 0; m_last[i] = N - 1; m_pre[i] = 0;
        end
        step();
        step();
        chk_en = 1'b1;

        // Idle: no requests, nothing granted.
        reset = 1'b0;
        for (int c = 0; c < 5; c++) begin
            step();
            chk("idle_gnt", int'(gnt_o[0]), 0);
            chk("idle_pre", int'(pre_o[0]), 0);
        end

        // Each holder drops its request after 3 grant cycles and reasserts one cycle later.
        reset_pulse();
        req_i[0] = 4'b1111; req_i[1] = 4'b1010; req_i[2] = 4'b1111;
        for (int i = 0; i < NI; i++) dropped[i] = -1;
        prev_busy = 1'b0;
        u1_ch3 = 0;
        for (int c = 0; c < 40; c++) begin
            step();
            if (busy_o[0] && !prev_busy) ord.push_back(int'(gnt_id_o[0]));
            prev_busy = busy_o[0];
            if (gnt_o[1][3]) u1_ch3++;
            for (int i = 0; i < NI; i++) begin
                if (dropped[i] >= 0) begin
                    req_i[i][dropped[i]] = 1'b1;
                    dropped[i] = -1;
                end
                if (m_cur[i] >= 0 && m_hold[i] == 3) begin
                    req_i[i][m_cur[i]] = 1'b0;
                    dropped[i] = m_cur[i];
                end
            end
        end
        chk("rr_grant_count_ge5", int'(ord.size() >= 5), 1);
        if (ord.size() >= 5) begin
            chk("rr_order0", ord[0], 0);
            chk("rr_order1", ord[1], 1);
            chk("rr_order2", ord[2], 2);
            chk("rr_order3", ord[3], 3);
            chk("rr_order4", ord[4], 0);
        end
        chk("fixed_ch3_never", u1_ch3, 0);

        // Hold limit: ch2 holds, ch0 arrives at grant cycle 3, ch2 preempted after 8 cycles.
        reset_pulse();
        req_i[0] = 4'b0100;
        exp_g = '{4, 4, 4, 4, 4, 4, 4, 4, 0, 1};
        exp_p = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0};
        for (int k = 0; k < 10; k++) begin
            step();
            if (m_hold[0] == 3 && m_cur[0] == 2) req_i[0] = 4'b0101;
            chk($sformatf("hold_trace_gnt%0d", k), int'(gnt_o[0]), exp_g[k]);
            chk($sformatf("hold_trace_pre%0d", k), int'(pre_o[0]), exp_p[k]);
        end

        // Lone holder keeps the grant past the limit; u1 holds long enough to saturate its count.
        reset_pulse();
        req_i[0] = 4'b0010; req_i[1] = 4'b0100; req_i[2] = 4'b0001;
        pre_seen = 0;
        for (int c = 0; c < 20; c++) begin
            step();
            pre_seen += int'(pre_o[0]);
        end
        chk("lone_gnt", int'(gnt_o[0]), 4'b0010);
        chk("lone_no_preempt", pre_seen, 0);
        req_i[0] = 4'b1010;
        step();
        chk("late_arrival_gnt", int'(gnt_o[0]), 0);
        chk("late_arrival_pre", int'(pre_o[0]), 1);
        for (int c = 0; c < 240; c++) step();
        req_i[1] = 4'b1100;
        req_i[2] = 4'b1001;
        step();
        chk("saturated_pre", int'(pre_o[1]), 1);
        chk("unlimited_no_pre", int'(pre_o[2]), 0);
        chk("unlimited_gnt", int'(gnt_o[2]), 4'b0001);

        // Reset in the middle of a grant, then channel 0 first.
        reset_pulse();
        req_i = {NI{4'b0100}};
        step();
        chk("mid_grant_gnt", int'(gnt_o[0]), 4'b0100);
        reset = 1'b1;
        step();
        chk("mid_reset_gnt", int'(gnt_o[0]), 0);
        reset = 1'b0;
        req_i = {NI{4'b1111}};
        step();
        chk("post_reset_gnt", int'(gnt_o[0]), 4'b0001);
        chk("post_reset_id", int'(gnt_id_o[0]), 0);

        // Random bursty traffic with occasional resets.
        for (int c = 0; c < 3000; c++) begin
            step();
            reset = ($urandom_range(299) == 0);
            for (int i = 0; i < NI; i++) begin
                for (int b = 0; b < N; b++) begin
                    if (req_i[i][b]) begin
                        if ($urandom_range(5) == 0) req_i[i][b] = 1'b0;
                    end else if ($urandom_range(3) == 0) begin
                        req_i[i][b] = 1'b1;
                    end
                end
            end
        end
        reset = 1'b0;
        step();
        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
